// File: rtl/vsa_mc_core.sv
// vsa_mc_core: parametrised multicycle VSA core.
// Non-pipelined IF/ID/EX/MEM/WB sequencer with memory wait states.
module vsa_mc_core #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              rst,
    output logic [PC_W-1:0]   pc,
    input  logic [15:0]       instruction,
    input  logic              imem_rdy,
    output logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              rd,
    output logic              wr,
    input  logic              dmem_rdy,
    output logic              halted,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_HLT = 3'd5
    } state_t;

    localparam logic [2:0] OP_LW   = 3'd0;
    localparam logic [2:0] OP_SW   = 3'd1;
    localparam logic [2:0] OP_BEQZ = 3'd2;
    localparam logic [2:0] OP_ALU  = 3'd3;
    localparam logic [2:0] OP_ADDI = 3'd4;
    localparam logic [2:0] OP_SUBI = 3'd5;
    localparam logic [2:0] OP_BNEZ = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [PC_W-1:0]   pc_q, npc_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, alu_q, lmd_q;
    logic              cond_q;
    logic [CNT_W-1:0]  ret_q;

    logic [2:0]        op;
    logic [1:0]        rs1, rs2, rdi, wdst;
    logic [6:0]        fun;
    logic [DATA_W-1:0] imm, npc_ext, alu_d;
    logic              is_mem, mem_done, is_br, wen;

    assign op     = ir_q[2:0];
    assign rs1    = ir_q[4:3];
    assign rs2    = ir_q[6:5];
    assign rdi    = ir_q[8:7];
    assign fun    = ir_q[15:9];
    assign imm    = {{(DATA_W-9){ir_q[15]}}, ir_q[15:7]};
    assign is_mem = (op == OP_LW) || (op == OP_SW);
    assign is_br  = (op == OP_BEQZ) || (op == OP_BNEZ);
    assign mem_done = !is_mem || dmem_rdy;
    assign wdst   = (op == OP_ALU) ? rdi : rs2;
    assign wen    = (op == OP_ALU) || (op == OP_ADDI) ||
                    (op == OP_SUBI) || (op == OP_LW);

    assign pc      = pc_q;
    assign alu_out = alu_q;
    assign dataout = b_q;
    assign rd      = (state_q == S_MEM) && (op == OP_LW);
    assign wr      = (state_q == S_MEM) && (op == OP_SW);
    assign halted  = (state_q == S_HLT);
    assign state   = state_q;
    assign retired = ret_q;

    // Control state register.
    always_ff @(posedge clock) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    // Next-state sequencing, stalling on memory handshakes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IF:  if (imem_rdy) state_d = S_ID;
            S_ID:  state_d = (op == OP_HALT) ? S_HLT : S_EX;
            S_EX:  state_d = S_MEM;
            S_MEM: if (mem_done) state_d = S_WB;
            S_WB:  state_d = S_IF;
            S_HLT: state_d = S_HLT;
            default: state_d = S_IF;
        endcase
    end

    // Execute-stage result: address, arithmetic or branch target.
    always_comb begin
        npc_ext = '0;
        npc_ext[PC_W-1:0] = npc_q;
        alu_d = alu_q;
        case (op)
            OP_LW, OP_SW, OP_ADDI: alu_d = a_q + imm;
            OP_SUBI:               alu_d = a_q - imm;
            OP_BEQZ, OP_BNEZ:      alu_d = npc_ext + (imm << 1);
            OP_ALU: begin
                case (fun)
                    7'd0: alu_d = a_q + b_q;
                    7'd1: alu_d = a_q - b_q;
                    7'd2: alu_d = a_q & b_q;
                    7'd3: alu_d = a_q | b_q;
                    7'd4: alu_d = a_q ^ b_q;
                    7'd5: alu_d = a_q >> 1;
                    default: alu_d = alu_q;
                endcase
            end
            default: alu_d = alu_q;
        endcase
    end

    // Datapath registers updated per control state.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            pc_q   <= '0;
            npc_q  <= '0;
            ir_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            alu_q  <= '0;
            cond_q <= 1'b0;
            lmd_q  <= '0;
            ret_q  <= '0;
        end else begin
            case (state_q)
                S_IF: begin
                    if (imem_rdy) begin
                        ir_q  <= instruction;
                        npc_q <= pc_q + PC_W'(2);
                    end
                end
                S_ID: begin
                    a_q <= (rs1 == 2'd0) ? '0 : regs_q[rs1];
                    b_q <= (rs2 == 2'd0) ? '0 : regs_q[rs2];
                end
                S_EX: begin
                    alu_q <= alu_d;
                    if (is_br)
                        cond_q <= (op == OP_BEQZ) ? (a_q == '0)
                                                  : (a_q != '0);
                end
                S_MEM: begin
                    if (mem_done) begin
                        if (op == OP_LW) lmd_q <= datain;
                        if (is_br && cond_q) pc_q <= alu_q[PC_W-1:0];
                        else                 pc_q <= npc_q;
                    end
                end
                S_WB: begin
                    if (wen && wdst != 2'd0)
                        regs_q[wdst] <= (op == OP_LW) ? lmd_q : alu_q;
                    ret_q <= ret_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vsa_mc_core.sv
// tb_vsa_mc_core: random + directed programs checked against an
// instruction-level model through a retirement scoreboard.
module tb_vsa_mc_core;

    localparam int DW = 16;
    localparam int PW = 12;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] pc;
    logic [15:0]   instruction;
    logic          imem_rdy;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;
    logic          rd;
    logic          wr;
    logic          dmem_rdy;
    logic          halted;
    logic [2:0]    state;
    logic [CW-1:0] retired;

    vsa_mc_core #(.DATA_W(DW), .PC_W(PW), .CNT_W(CW)) dut (
        .clock(clock), .rst(rst), .pc(pc),
        .instruction(instruction), .imem_rdy(imem_rdy),
        .alu_out(alu_out), .datain(datain), .dataout(dataout),
        .rd(rd), .wr(wr), .dmem_rdy(dmem_rdy), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]    op;
        logic [PW-1:0] pc;
        logic [CW-1:0] ret;
        logic [DW-1:0] alu;
        logic [DW-1:0] sdata;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    logic [15:0] imem [2048];

    logic [DW-1:0] mr [4];
    logic [PW-1:0] mpc;
    logic [CW-1:0] mret;
    logic [DW-1:0] malu;

    function automatic logic [DW-1:0] dm(input logic [DW-1:0] a);
        logic [DW-1:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = '0;
        mpc = '0;
        mret = '0;
        malu = '0;
    endtask

    // Instruction-set level execution of one instruction.
    task automatic model_exec(input logic [15:0] ins, output exp_t e);
        logic [2:0]    op;
        logic [1:0]    wd;
        logic [DW-1:0] a, b, imm, wv;
        logic [PW-1:0] npc, nxt;
        logic          we;
        op  = ins[2:0];
        a   = mr[ins[4:3]];
        b   = mr[ins[6:5]];
        imm = {{(DW-9){ins[15]}}, ins[15:7]};
        npc = mpc + 2;
        nxt = npc;
        we  = 1'b0;
        wd  = ins[6:5];
        wv  = '0;
        case (op)
            3'd0: begin
                malu = a + imm; wv = dm(malu); we = 1'b1;
            end
            3'd1: malu = a + imm;
            3'd2, 3'd6: begin
                malu = DW'(npc) + (imm << 1);
                if ((op == 3'd2) == (a == '0)) nxt = malu[PW-1:0];
            end
            3'd3: begin
                case (ins[15:9])
                    7'd0: malu = a + b;
                    7'd1: malu = a - b;
                    7'd2: malu = a & b;
                    7'd3: malu = a | b;
                    7'd4: malu = a ^ b;
                    7'd5: malu = a >> 1;
                    default: ;
                endcase
                wv = malu; wd = ins[8:7]; we = 1'b1;
            end
            3'd4: begin malu = a + imm; wv = malu; we = 1'b1; end
            3'd5: begin malu = a - imm; wv = malu; we = 1'b1; end
            default: nxt = mpc;
        endcase
        if (we && wd != 2'd0) mr[wd] = wv;
        if (op != 3'd7) mret++;
        mpc = nxt;
        e.op = op;
        e.pc = mpc;
        e.ret = mret;
        e.alu = malu;
        e.sdata = b;
        e.cyc = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rnd_bus();
        imem_rdy = 1'($urandom);
        instruction = 16'($urandom);
        dmem_rdy = 1'($urandom);
        datain = DW'($urandom);
    endtask

    // Drives one instruction with planned wait states; no DUT reads.
    task automatic run_insn(output logic [2:0] op);
        exp_t e;
        int iw, dw;
        iw = $urandom_range(0, 2);
        for (int k = 0; k < iw; k++) begin
            rnd_bus(); imem_rdy = 1'b0; tick();
        end
        rnd_bus();
        imem_rdy = 1'b1;
        instruction = imem[mpc[PW-1:1]];
        model_exec(instruction, e);
        op = e.op;
        dw = (op <= 3'd1) ? $urandom_range(0, 3) : 0;
        e.cyc = 5 + iw + dw;
        q.push_back(e);
        tick();
        rnd_bus(); tick();
        if (op == 3'd7) return;
        rnd_bus(); tick();
        for (int k = 0; k < dw; k++) begin
            rnd_bus(); dmem_rdy = 1'b0; tick();
        end
        rnd_bus();
        if (op <= 3'd1) dmem_rdy = 1'b1;
        if (op == 3'd0) datain = dm(e.alu);
        tick();
        rnd_bus(); tick();
    endtask

    int rst_edges = 0;
    always @(posedge clock) begin
        if (rst) rst_edges++;
        else     rst_edges = 0;
    end

    logic [2:0]    prev = 3'd0;
    int            cyc = 0;
    bit            memseen = 0;
    logic [PW-1:0] hpc;
    logic [CW-1:0] hret;

    // Monitor: pops expectations at retirement and halt entry.
    always @(negedge clock) begin
        exp_t e;
        if (rst) begin
            if (rst_edges > 0)
                chk("reset_state",
                    {pc, state, halted, retired, alu_out, dataout, rd, wr},
                    64'd0);
            prev = 3'd0; cyc = 0; memseen = 0;
        end else begin
            if (rd || wr) begin
                memseen = 1;
                if (q.size() == 0) chk("strobe_no_expect", 1, 0);
                else begin
                    chk("strobe_kind", {rd, wr},
                        (q[0].op == 3'd0) ? 2'b10 :
                        (q[0].op == 3'd1) ? 2'b01 : 2'b00);
                    chk("mem_addr", alu_out, q[0].alu);
                    if (wr) chk("store_data", dataout, q[0].sdata);
                end
            end
            if (state == 3'd0 && prev == 3'd4) begin
                if (q.size() == 0) chk("retire_no_expect", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("retire_pc", pc, e.pc);
                    chk("retire_count", retired, e.ret);
                    chk("retire_alu", alu_out, e.alu);
                    chk("retire_cycles", cyc, e.cyc);
                    chk("retire_strobe", memseen, e.op <= 3'd1);
                end
                cyc = 1;
                memseen = 0;
            end else cyc++;
            if (state == 3'd5) begin
                if (prev != 3'd5) begin
                    if (q.size() == 0) chk("halt_no_expect", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("halt_pc", pc, e.pc);
                        chk("halt_count", retired, e.ret);
                        chk("halt_op", e.op, 3'd7);
                        hpc = e.pc;
                        hret = e.ret;
                    end
                end
                chk("halt_hold", {halted, pc, retired, rd, wr},
                    {1'b1, hpc, hret, 2'b00});
            end
            prev = state;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        logic [15:0] w;
        rnd_bus();
        imem_rdy = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            w = 16'($urandom);
            w[2:0] = 3'($urandom_range(0, 6));
            if (w[2:0] == 3'd3) w[15:9] = 7'($urandom_range(0, 6));
            imem[i] = w;
        end
        model_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int n = 0; n < 300; n++) run_insn(op);
        imem_rdy = 1'b0;
        for (int k = 0; k < 20 && q.size() != 0; k++) tick();
        chk("drain_random", q.size(), 0);

        rst = 1'b1;
        rnd_bus();
        tick(); tick();
        imem[0]  = 16'h02A4;
        imem[1]  = 16'h0248;
        imem[2]  = 16'h0041;
        imem[3]  = 16'hFFA4;
        imem[4]  = 16'h0B0B;
        imem[5]  = 16'hFE86;
        imem[6]  = 16'h0041;
        imem[7]  = 16'h0102;
        imem[8]  = 16'h00A4;
        imem[9]  = 16'h00A4;
        imem[10] = 16'h0007;
        model_reset();
        rst = 1'b0;
        op = 3'd0;
        for (int n = 0; n < 20 && op != 3'd7; n++) run_insn(op);
        chk("directed_halt_reached", op, 3'd7);
        chk("directed_r2", mr[2], 16'h7FFF);
        for (int k = 0; k < 8; k++) begin rnd_bus(); tick(); end
        chk("drain_directed", q.size(), 0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        imem_rdy = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
